// File: rtl/bcd_encoder.sv
// bcd_encoder: sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// Valid/ready handshakes on both sides. Optional build macro BCD_ENCODER_SATURATE_EN
// clamps overflowed results to all nines; by default the low N digits are returned.
`timescale 1ns/1ps

module bcd_encoder #(
  parameter  int unsigned N = 3,
  localparam int unsigned W = 3*N + (N+2)/3
) (
  input  logic           i_clock,
  input  logic           i_reset,
  input  logic [W-1:0]   i_bin,
  input  logic           i_valid,
  output logic           o_ready,
  output logic [4*N-1:0] o_bcd,
  output logic           o_overflow,
  output logic           o_valid,
  input  logic           i_ready
);

  localparam int unsigned AW = 4*(N+1);
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [W-1:0]   bin_q, bin_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [CW-1:0]  count_q, count_d;
  logic [4*N-1:0] bcd_q, bcd_d;
  logic           ovf_q, ovf_d;
  logic           valid_q, valid_d;
  logic           ready_q, ready_d;

  logic [AW-1:0]  acc_adj;
  logic [4*N-1:0] bcd_res;
  logic           ovf_res;

  // Add 3 to every scratch digit that is 5 or more before the next shift
  always_comb begin
    acc_adj = acc_q;
    for (int unsigned i = 0; i <= N; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Final result formatting; the extra top digit flags overflow
  always_comb begin
    ovf_res = (acc_q[4*N +: 4] != 4'd0);
`ifdef BCD_ENCODER_SATURATE_EN
    bcd_res = ovf_res ? {N{4'd9}} : acc_q[4*N-1:0];
`else
    bcd_res = acc_q[4*N-1:0];
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    count_d = count_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          bin_d   = i_bin;
          acc_d   = '0;
          count_d = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {acc_d, bin_d} = {acc_adj[AW-2:0], bin_q, 1'b0};
        count_d        = count_q + CW'(1);
        if (count_q == CW'(W-1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // First DONE cycle registers the result; then hold until it is taken
        if (!valid_q) begin
          bcd_d   = bcd_res;
          ovf_d   = ovf_res;
          valid_d = 1'b1;
        end else if (i_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_valid    = valid_q;
  assign o_bcd      = bcd_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_bcd_encoder.sv
// Scoreboard bench for bcd_encoder with N=3 (W=10).
`timescale 1ns/1ps

module tb_bcd_encoder;

  localparam int unsigned N = 3;
  localparam int unsigned W = 10;

  typedef struct packed {
    logic        ovf;
    logic [11:0] bcd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  bin;
  logic          in_valid;
  logic          out_ready;
  logic [11:0]   bcd;
  logic          ovf;
  logic          out_valid;
  logic          down_ready;

  exp_t exp_q[$];
  exp_t mon_e;
  exp_t drop_e;
  int   checks = 0;
  int   errors = 0;
  int   n_xfer = 0;
  bit   rand_rdy = 1'b0;

  bcd_encoder #(.N(N)) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_bin      (bin),
    .i_valid    (in_valid),
    .o_ready    (out_ready),
    .o_bcd      (bcd),
    .o_overflow (ovf),
    .o_valid    (out_valid),
    .i_ready    (down_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t ref_model(input int v);
    exp_t r;
    int   m;
    m     = v % 1000;
    r.ovf = (v >= 1000);
    r.bcd = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
`ifdef BCD_ENCODER_SATURATE_EN
    if (r.ovf) r.bcd = 12'h999;
`endif
    return r;
  endfunction

  // Monitor: compare every output transfer and the held value under backpressure
  always @(negedge clk) begin
    if (!rst) begin
      check("ready_valid_exclusive", 32'(out_ready & out_valid), 32'd0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(out_valid), 32'd0);
        end else if (down_ready) begin
          mon_e = exp_q.pop_front();
          check("bcd", 32'(bcd), 32'(mon_e.bcd));
          check("overflow", 32'(ovf), 32'(mon_e.ovf));
          n_xfer++;
        end else begin
          mon_e = exp_q[0];
          check("hold_bcd", 32'(bcd), 32'(mon_e.bcd));
          check("hold_overflow", 32'(ovf), 32'(mon_e.ovf));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) down_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [W-1:0] v, input exp_t e);
    int t;
    t        = 0;
    bin      = v;
    in_valid = 1'b1;
    while (!out_ready && t < 500) begin
      tick();
      t++;
    end
    if (!out_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(e);
      tick();
      in_valid = 1'b0;
      bin      = W'($urandom);
    end
  endtask

  task automatic wait_latency(input string name);
    int lat;
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check(name, 32'(lat), 32'd11);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      tick();
      t++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic run_one(input logic [W-1:0] v, input logic [11:0] eb, input logic eo);
    exp_t e;
    e.bcd = eb;
    e.ovf = eo;
    send(v, e);
    wait_latency("latency");
    drain("drain");
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int x0;
    rst        = 1'b1;
    in_valid   = 1'b1;
    bin        = 10'd5;
    down_ready = 1'b1;

    // Reset with i_valid asserted: nothing accepted, outputs quiet
    repeat (3) tick();
    check("rst_ready", 32'(out_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_overflow", 32'(ovf), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_ready", 32'(out_ready), 32'd1);
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_bcd", 32'(bcd), 32'd0);
      check("idle_overflow", 32'(ovf), 32'd0);
    end

    // Directed conversions
    run_one(10'd0, 12'h000, 1'b0);
    run_one(10'd255, 12'h255, 1'b0);
    run_one(10'd999, 12'h999, 1'b0);
`ifdef BCD_ENCODER_SATURATE_EN
    run_one(10'd1023, 12'h999, 1'b1);
`else
    run_one(10'd1023, 12'h023, 1'b1);
`endif

    // Backpressure: result held for 7 cycles, single transfer
    down_ready = 1'b0;
    x0         = n_xfer;
    run_bp : begin
      exp_t e;
      e.bcd = 12'h512;
      e.ovf = 1'b0;
      send(10'd512, e);
    end
    wait_latency("bp_latency");
    for (int i = 0; i < 7; i++) begin
      tick();
      check("bp_ready", 32'(out_ready), 32'd0);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    down_ready = 1'b1;
    check("bp_ready_before_release", 32'(out_ready), 32'd0);
    tick();
    check("bp_ready_after_release", 32'(out_ready), 32'd1);
    check("bp_valid_after_release", 32'(out_valid), 32'd0);
    repeat (3) tick();
    check("bp_transfers", 32'(n_xfer - x0), 32'd1);

    // Reset mid-conversion: result discarded, next conversion normal
    run_abort : begin
      exp_t e;
      e.bcd = 12'h777;
      e.ovf = 1'b0;
      send(10'd777, e);
    end
    repeat (4) tick();
    rst    = 1'b1;
    drop_e = exp_q.pop_back();
    repeat (2) tick();
    rst = 1'b0;
    x0  = n_xfer;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    check("abort_transfers", 32'(n_xfer - x0), 32'd0);
    run_one(10'd42, 12'h042, 1'b0);

    // Full sweep with random input gaps and random downstream stalls
    x0       = n_xfer;
    rand_rdy = 1'b1;
    for (int v = 0; v < 1024; v++) begin
      repeat ($urandom_range(0, 2)) tick();
      send(W'(v), ref_model(v));
    end
    rand_rdy   = 1'b0;
    down_ready = 1'b1;
    drain("sweep_drain");
    check("sweep_transfers", 32'(n_xfer - x0), 32'd1024);

    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_encoder.md
# bcd_encoder

Sequential binary-to-BCD encoder using the shift-add-3 ("double dabble") algorithm, one input bit per clock. It is the inverse of the combinational BCD decoder: it accepts a binary word as wide as that decoder's output and returns N packed BCD digits. Both ends use valid/ready handshakes, so it can sit between streaming datapath stages and display or serial-formatting logic. It trades latency for area: only N+1 adder-compare cells are used, not a full combinational array.

## Interface
- N, 3, number of BCD output digits (N ≥ 1)
- W (localparam), 3*N+(N+2)/3, binary input width, equal to the decoder's binary width

- i_clock  input  1  rising-edge clock
- i_reset  input  1  reset, synchronous and active-high
- i_bin  input  W  binary value to convert, sampled on input handshake
- i_valid  input  1  i_bin is valid
- o_ready  output  1  encoder can accept a new value
- o_bcd  output  4*N  packed BCD result, digit 0 in [3:0]
- o_overflow  output  1  input value ≥ 10^N
- o_valid  output  1  o_bcd/o_overflow valid
- i_ready  input  1  downstream accepts the result

## Operation
- Datapath:
  - W-bit shift register `bin`.
  - (N+1)-digit scratch register `acc`. The extra digit detects overflow; W bits always fit in N+1 digits.
  - W-range bit counter.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid & o_ready: bin←i_bin, acc←0, count←0, go to SHIFT.
- SHIFT, one bit per cycle:
  - Each digit of acc that is ≥5 gets +3.
  - Then {acc,bin} shifts left by 1.
  - count increments.
  - After the W-th shift, go to DONE.
  - o_ready=0.
- DONE:
  - o_valid=1.
  - o_bcd and o_overflow are held stable until i_valid... the downstream handshake: until o_valid & i_ready.
  - On that handshake, go to IDLE.
- o_overflow = (acc digit N ≠ 0).
- Inputs are ignored outside IDLE.
- i_bin is not required to stay stable after acceptance.

## Timing
- Reset values: o_ready=0 during reset, 1 in the first cycle after reset release. o_valid=0, o_bcd=0, o_overflow=0. State is IDLE.
- Latency:
  - Input handshake at edge k; result valid (o_valid=1) from edge k+W+1.
  - Exactly W SHIFT cycles, independent of the value.
- After the output handshake at edge m, o_ready=1 from edge m.
- Throughput: at most one conversion per W+2 cycles.
- The input handshake and output handshake are never simultaneously possible. o_ready and o_valid are mutually exclusive.
- Backpressure: DONE persists indefinitely while i_ready=0, with outputs held constant.
- Reset mid-operation (SHIFT or DONE): the conversion is aborted and discarded. No o_valid pulse follows.
- i_valid asserted during reset is not accepted.
- o_bcd digits are always in 0..9, including on overflow.

## Configuration
- Macro: BCD_ENCODER_SATURATE_EN.
- Defined: on overflow, o_bcd = all digits 9 (e.g. 12'h999 for N=3), with o_overflow=1.
- Undefined: on overflow, o_bcd = the low N digits of the true decimal value (value mod 10^N), with o_overflow=1.
- Non-overflow results are identical in both builds.

## Test plan
All scenarios use N=3 (W=10).
- Reset release, i_valid held 0: o_ready=1, o_valid=0, o_bcd=0, o_overflow=0 for 20 cycles.
- i_bin=0, then 255, then 999, with i_ready=1: o_bcd=12'h000, 12'h255, 12'h999 respectively. o_overflow=0. o_valid rises exactly 11 cycles after each accept.
- i_bin=1023: o_overflow=1. o_bcd=12'h999 with BCD_ENCODER_SATURATE_EN defined, 12'h023 without it.
- i_bin=512 with i_ready=0 for 7 cycles after o_valid: o_bcd stays 12'h512. o_ready stays 0 until the cycle after i_ready rises. Exactly one output transfer occurs.
- i_reset pulsed 5 cycles after accepting 777: no o_valid appears. The next input 42 returns 12'h042 with latency 11.
- Exhaustive sweep 0..1023 with random i_valid/i_ready gaps: every result matches the reference model, order is preserved, and there are no drops or duplicates.
